vga_ctrl: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_axis_counter.sv | 37 +++
 rtl/vga_ctrl.sv | 101 ++++++++++
 tb/tb_vga_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and derived values shared by the VGA controller.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned RGB_W = 8;

    localparam int unsigned H_SYNC_DEF  = 96;
    localparam int unsigned H_BACK_DEF  = 48;
    localparam int unsigned H_VALID_DEF = 640;
    localparam int unsigned H_FRONT_DEF = 16;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BACK_DEF  = 33;
    localparam int unsigned V_VALID_DEF = 480;
    localparam int unsigned V_FRONT_DEF = 10;

    localparam logic SYNC_POL_DEF = 1'b0;

    localparam int unsigned H_TOTAL     = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
    localparam int unsigned V_TOTAL     = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;
    localparam int unsigned H_ACT_START = H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_VALID_DEF;
    localparam int unsigned V_ACT_START = V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_VALID_DEF;

    // Coordinate value presented outside the active picture
    localparam logic [CNT_W-1:0] COORD_NONE = '1;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with sync/active region decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL     = H_TOTAL,
    parameter int unsigned SYNC      = H_SYNC_DEF,
    parameter int unsigned ACT_START = H_ACT_START,
    parameter int unsigned ACT_LEN   = H_VALID_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_act,
    output logic [CNT_W-1:0] coord
);

    // Position counter, advances on inc and wraps at the end of the axis
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    // Region decode from the current position
    always_comb begin
        wrap    = inc && (cnt == CNT_W'(TOTAL - 1));
        in_sync = (cnt < CNT_W'(SYNC));
        in_act  = (cnt >= CNT_W'(ACT_START)) && (cnt < CNT_W'(ACT_START + ACT_LEN));
        coord   = in_act ? (cnt - CNT_W'(ACT_START)) : COORD_NONE;
    end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator and registered pin stage for the ADV7123 DAC.
module vga_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BACK   = H_BACK_DEF,
    parameter int unsigned H_VALID  = H_VALID_DEF,
    parameter int unsigned H_FRONT  = H_FRONT_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BACK   = V_BACK_DEF,
    parameter int unsigned V_VALID  = V_VALID_DEF,
    parameter int unsigned V_FRONT  = V_FRONT_DEF,
    parameter logic        SYNC_POL = SYNC_POL_DEF
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    input  logic [RGB_W-1:0] i_r,
    input  logic [RGB_W-1:0] i_g,
    input  logic [RGB_W-1:0] i_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             vga_sync_n,
    output logic [RGB_W-1:0] vga_r,
    output logic [RGB_W-1:0] vga_g,
    output logic [RGB_W-1:0] vga_b,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt, v_cnt, h_coord, v_coord;
    logic             h_wrap, h_sync, h_act;
    logic             v_sync, v_act;
    logic             unused_v_wrap;
    logic             active;

    vga_axis_counter #(
        .TOTAL    (H_SYNC + H_BACK + H_VALID + H_FRONT),
        .SYNC     (H_SYNC),
        .ACT_START(H_SYNC + H_BACK),
        .ACT_LEN  (H_VALID)
    ) u_h_axis (
        .clk    (vga_clk),
        .rst_n  (sys_rst_n),
        .inc    (1'b1),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .in_sync(h_sync),
        .in_act (h_act),
        .coord  (h_coord)
    );

    vga_axis_counter #(
        .TOTAL    (V_SYNC + V_BACK + V_VALID + V_FRONT),
        .SYNC     (V_SYNC),
        .ACT_START(V_SYNC + V_BACK),
        .ACT_LEN  (V_VALID)
    ) u_v_axis (
        .clk    (vga_clk),
        .rst_n  (sys_rst_n),
        .inc    (h_wrap),
        .cnt    (v_cnt),
        .wrap   (unused_v_wrap),
        .in_sync(v_sync),
        .in_act (v_act),
        .coord  (v_coord)
    );

    // Coordinates to the picture source, parked at all-ones outside the picture
    always_comb begin
        active = h_act && v_act;
        pix_x  = active ? h_coord : COORD_NONE;
        pix_y  = active ? v_coord : COORD_NONE;
    end

    // No sync-on-green
    assign vga_sync_n = 1'b0;

    // Single pin register stage, keeps sync, blank and colour aligned
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= h_sync ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= v_sync ? SYNC_POL : ~SYNC_POL;
            vga_blank_n <= active;
            vga_r       <= active ? i_r : '0;
            vga_g       <= active ? i_g : '0;
            vga_b       <= active ? i_b : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: default-timing instance with directed checks, small-timing instance with a scoreboard.
module tb_vga_ctrl;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default 640x480 instance
    logic       rst_a = 1'b0;
    logic [9:0] a_px, a_py;
    logic [7:0] a_ir, a_ig, a_ib;
    logic       a_hs, a_vs, a_bn, a_sn, a_fs;
    logic [7:0] a_r, a_g, a_b;

    vga_ctrl u_dut_a (
        .vga_clk    (vga_clk),
        .sys_rst_n  (rst_a),
        .pix_x      (a_px),
        .pix_y      (a_py),
        .i_r        (a_ir),
        .i_g        (a_ig),
        .i_b        (a_ib),
        .vga_hs     (a_hs),
        .vga_vs     (a_vs),
        .vga_blank_n(a_bn),
        .vga_sync_n (a_sn),
        .vga_r      (a_r),
        .vga_g      (a_g),
        .vga_b      (a_b),
        .frame_start(a_fs)
    );

    // Small instance: H 4/3/8/2 (17), V 2/2/4/1 (9), active h 7..14, v 4..7
    logic       rst_s = 1'b0;
    logic       mode_s = 1'b0;
    logic [9:0] s_px, s_py;
    logic [7:0] s_ir, s_ig, s_ib;
    logic       s_hs, s_vs, s_bn, s_sn, s_fs;
    logic [7:0] s_r, s_g, s_b;

    assign s_ir = mode_s ? s_px[7:0] : 8'hFF;
    assign s_ig = 8'h80;
    assign s_ib = 8'h40;

    vga_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
        .SYNC_POL(1'b0)
    ) u_dut_s (
        .vga_clk    (vga_clk),
        .sys_rst_n  (rst_s),
        .pix_x      (s_px),
        .pix_y      (s_py),
        .i_r        (s_ir),
        .i_g        (s_ig),
        .i_b        (s_ib),
        .vga_hs     (s_hs),
        .vga_vs     (s_vs),
        .vga_blank_n(s_bn),
        .vga_sync_n (s_sn),
        .vga_r      (s_r),
        .vga_g      (s_g),
        .vga_b      (s_b),
        .frame_start(s_fs)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic       sync_n;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [9:0] px;
        logic [9:0] py;
    } obs_t;

    obs_t sq[$];
    bit   s_done = 1'b0;

    // Small-instance reference state
    int   mh = 0;
    int   mv = 0;
    bit   rprev = 1'b0;
    bit   cur_m = 1'b0;
    obs_t mp = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, sync_n: 1'b0, fs: 1'b0,
                 r: 8'h00, g: 8'h00, b: 8'h00, px: 10'h3FF, py: 10'h3FF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One small-instance cycle: apply the past clock edge to the model, then this cycle's reset/mode
    task automatic s_cycle(input bit r, input bit m);
        logic act;
        @(negedge vga_clk);
        if (rprev) begin
            act        = (mh >= 7 && mh < 15) && (mv >= 4 && mv < 8);
            mp.hs      = (mh < 4) ? 1'b0 : 1'b1;
            mp.vs      = (mv < 2) ? 1'b0 : 1'b1;
            mp.blank_n = act;
            mp.fs      = (mh == 0 && mv == 0);
            mp.r       = !act ? 8'h00 : (cur_m ? 8'(mh - 7) : 8'hFF);
            mp.g       = act ? 8'h80 : 8'h00;
            mp.b       = act ? 8'h40 : 8'h00;
            if (mh == 16) begin
                mh = 0;
                mv = (mv == 8) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        cur_m  = m;
        mode_s = m;
        rst_s  = r;
        if (!r) begin
            mh = 0; mv = 0;
            mp.hs = 1'b1; mp.vs = 1'b1; mp.blank_n = 1'b0; mp.fs = 1'b0;
            mp.r = 8'h00; mp.g = 8'h00; mp.b = 8'h00;
        end
        rprev     = r;
        mp.sync_n = 1'b0;
        act       = (mh >= 7 && mh < 15) && (mv >= 4 && mv < 8);
        mp.px     = act ? 10'(mh - 7) : 10'h3FF;
        mp.py     = act ? 10'(mv - 4) : 10'h3FF;
        sq.push_back(mp);
    endtask

    initial begin
        a_ir = 8'hFF;
        a_ig = 8'h80;
        a_ib = 8'h40;
        fork
            // Small-instance stimulus: reset, constant colour, coordinate colour, mid-frame reset
            begin
                repeat (4)   s_cycle(1'b0, 1'b0);
                repeat (320) s_cycle(1'b1, 1'b0);
                repeat (380) s_cycle(1'b1, 1'b1);
                repeat (3)   s_cycle(1'b0, 1'b1);
                repeat (320) s_cycle(1'b1, 1'b1);
                s_done = 1'b1;
            end
            // Small-instance monitor
            begin
                obs_t e, a;
                while (!s_done || sq.size() != 0) begin
                    @(negedge vga_clk);
                    #1;
                    a = {s_hs, s_vs, s_bn, s_sn, s_fs, s_r, s_g, s_b, s_px, s_py};
                    n_cmp++;
                    if (sq.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_underflow: got %h expected a queued entry", a);
                    end else begin
                        e = sq.pop_front();
                        if (a !== e) begin
                            n_err++;
                            $display("FAIL sb_pins: got %h expected %h", a, e);
                        end
                    end
                end
            end
            // Default-instance directed checks, k = cycles since reset release
            begin
                int fs_cnt = 0, hs_low = 0, bn_cnt = 0, overlap = 0, coord_bad = 0;
                repeat (4) @(negedge vga_clk);
                #1;
                chk("rst_hs", 32'(a_hs), 32'd1);
                chk("rst_vs", 32'(a_vs), 32'd1);
                chk("rst_blank", 32'(a_bn), 32'd0);
                chk("rst_sync_n", 32'(a_sn), 32'd0);
                chk("rst_fs", 32'(a_fs), 32'd0);
                chk("rst_rgb", 32'({a_r, a_g, a_b}), 32'd0);
                chk("rst_px", 32'(a_px), 32'h3FF);
                chk("rst_py", 32'(a_py), 32'h3FF);
                @(negedge vga_clk);
                rst_a = 1'b1;
                for (int k = 1; k <= 29000; k++) begin
                    @(negedge vga_clk);
                    #1;
                    if (a_fs) fs_cnt++;
                    if (k <= 800 && !a_hs) hs_low++;
                    if (k <= 28900 && a_bn) bn_cnt++;
                    if (a_bn && !a_vs) overlap++;
                    if ((a_px != 10'h3FF && a_px > 10'd639) || (a_py != 10'h3FF && a_py > 10'd479)) coord_bad++;
                    if (a_sn) coord_bad++;
                    case (k)
                        1: begin
                            chk("first_fs", 32'(a_fs), 32'd1);
                            chk("first_hs", 32'(a_hs), 32'd0);
                            chk("first_vs", 32'(a_vs), 32'd0);
                        end
                        2:     chk("fs_pulse_end", 32'(a_fs), 32'd0);
                        96:    chk("hs_last_low", 32'(a_hs), 32'd0);
                        97:    chk("hs_rise", 32'(a_hs), 32'd1);
                        800:   chk("hs_line_end", 32'(a_hs), 32'd1);
                        801:   chk("hs_period", 32'(a_hs), 32'd0);
                        1600:  chk("vs_last_low", 32'(a_vs), 32'd0);
                        1601:  chk("vs_rise", 32'(a_vs), 32'd1);
                        28144: begin
                            chk("px_first", 32'(a_px), 32'd0);
                            chk("py_first", 32'(a_py), 32'd0);
                            chk("bn_before", 32'(a_bn), 32'd0);
                            chk("r_before", 32'(a_r), 32'd0);
                        end
                        28145: begin
                            chk("bn_start", 32'(a_bn), 32'd1);
                            chk("rgb_active", 32'({a_r, a_g, a_b}), 32'hFF8040);
                            chk("px_step", 32'(a_px), 32'd1);
                        end
                        28783: chk("px_last", 32'(a_px), 32'd639);
                        28784: begin
                            chk("px_after", 32'(a_px), 32'h3FF);
                            chk("bn_last", 32'(a_bn), 32'd1);
                        end
                        28785: begin
                            chk("bn_end", 32'(a_bn), 32'd0);
                            chk("rgb_blank", 32'({a_r, a_g, a_b}), 32'd0);
                        end
                        28944: begin
                            chk("px_line2", 32'(a_px), 32'd0);
                            chk("py_line2", 32'(a_py), 32'd1);
                        end
                        default: ;
                    endcase
                end
                chk("fs_count", 32'(fs_cnt), 32'd1);
                chk("hs_low_len", 32'(hs_low), 32'd96);
                chk("bn_len", 32'(bn_cnt), 32'd640);
                chk("bn_in_vs", 32'(overlap), 32'd0);
                chk("coord_range", 32'(coord_bad), 32'd0);
                // Asynchronous reset in the middle of an active line
                rst_a = 1'b0;
                #1;
                chk("mid_rst_bn", 32'(a_bn), 32'd0);
                chk("mid_rst_px", 32'(a_px), 32'h3FF);
                chk("mid_rst_r", 32'(a_r), 32'd0);
                repeat (3) @(negedge vga_clk);
                rst_a = 1'b1;
                @(negedge vga_clk);
                #1;
                chk("restart_fs", 32'(a_fs), 32'd1);
                chk("restart_hs", 32'(a_hs), 32'd0);
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
